// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared MEM-stage types and constants
package cpu_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 4;
endpackage

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with stall-enable and bubble insertion
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        bubble,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic        read_en,
  input  logic [31:0] read_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_RegWrite   <= 1'b0;
      wb_MemtoReg   <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
    end else if (bubble) begin
      // Only the control bits are cleared; data fields are don't-care in a bubble
      wb_RegWrite <= 1'b0;
      wb_MemtoReg <= 1'b0;
    end else if (en) begin
      wb_RegWrite   <= reg_write;
      wb_MemtoReg   <= mem_to_reg;
      wb_alu_result <= alu_result;
      wb_rd         <= rd;
      if (read_en) wb_read_data <= read_data;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, timeout, branch resolution
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Jump,
  input  logic        ALU_zero,
  input  logic [31:0] jump_addr,
  input  logic [31:0] branch_addr,
  input  logic [31:0] ALU_result,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        mem_error,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd
);
  mem_state_t       state;
  logic [CNT_W-1:0] busy_cnt;
  logic             access;
  logic             misalign;
  logic             start;
  logic             busy;
  logic             done;
  logic             timeout;

  assign access   = MemRead | MemWrite;
  assign misalign = access & (ALU_result[1:0] != 2'b00);
  assign start    = (state == ST_IDLE) & access & !misalign;
  assign busy     = (state == ST_BUSY);
  assign done     = busy & dmem_ready;
  // busy_cnt is 0 in the first BUSY cycle, so TIMEOUT-1 marks the last allowed one
  assign timeout  = busy & !dmem_ready & (busy_cnt == CNT_W'(TIMEOUT - 1));

  assign dmem_req   = busy;
  assign dmem_we    = MemWrite;
  assign dmem_addr  = ALU_result;
  assign dmem_wdata = wdata;

  assign mem_stall   = start | (busy & !dmem_ready & !timeout);
  assign pc_redirect = Jump | (Branch & ALU_zero);
  assign pc_target   = Jump ? jump_addr : branch_addr;
  assign flush       = pc_redirect & !mem_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (start) begin
          state    <= ST_BUSY;
          busy_cnt <= '0;
        end
      end else if (done || timeout) begin
        state <= ST_IDLE;
      end else begin
        busy_cnt <= busy_cnt + 1'b1;
      end
      if (((state == ST_IDLE) && misalign) || timeout) mem_error <= 1'b1;
    end
  end

  mem_wb u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .en           (!mem_stall),
    .bubble       (mem_stall),
    .reg_write    (RegWrite & !misalign & !timeout),
    .mem_to_reg   (MemtoReg),
    .read_en      (done),
    .read_data    (dmem_rdata),
    .alu_result   (ALU_result),
    .rd           (rd),
    .wb_RegWrite  (wb_RegWrite),
    .wb_MemtoReg  (wb_MemtoReg),
    .wb_read_data (wb_read_data),
    .wb_alu_result(wb_alu_result),
    .wb_rd        (wb_rd)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with transaction-level model
module tb_mem_stage;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg, Branch, MemRead, MemWrite, Jump, ALU_zero;
  logic [31:0] jump_addr, branch_addr, ALU_result, wdata;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_redirect, flush, mem_error;
  logic [31:0] pc_target;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [31:0] wb_read_data, wb_alu_result;
  logic [4:0]  wb_rd;

  int errors = 0;
  int checks = 0;
  logic        exp_err;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .Jump(Jump), .ALU_zero(ALU_zero),
    .jump_addr(jump_addr), .branch_addr(branch_addr), .ALU_result(ALU_result),
    .wdata(wdata), .rd(rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .mem_error(mem_error),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_rd(wb_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    {RegWrite, MemtoReg, Branch, MemRead, MemWrite, Jump, ALU_zero} = '0;
    jump_addr = '0; branch_addr = '0; ALU_result = '0; wdata = '0; rd = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
  endtask

  // One instruction through MEM; memory raises ready after `delay` request cycles
  task automatic run_txn(input bit mr, input bit mw, input bit rw, input bit mtr,
                         input bit br, input bit z, input bit jmp,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [31:0] ja, input logic [31:0] ba, input logic [4:0] rdn,
                         input int delay);
    bit acc, mis, aligned, tout, redir;
    int stall_n, busy_n, req_seen, we_seen;
    bit finished;
    acc     = mr | mw;
    mis     = acc && (addr % 4 != 0);
    aligned = acc && !mis;
    tout    = aligned && (delay >= TO - 0) && (delay > TO - 1);
    busy_n  = !aligned ? 0 : (tout ? TO : delay + 1);
    stall_n = busy_n;
    redir   = jmp || (br && z);
    req_seen = 0; we_seen = 0; finished = 0;

    @(negedge clk);
    MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = mtr;
    Branch = br; ALU_zero = z; Jump = jmp;
    ALU_result = addr; wdata = wd; jump_addr = ja; branch_addr = ba; rd = rdn;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (dmem_req) begin
        dmem_ready = (req_seen == delay);
        dmem_rdata = dmem_ready ? rdv : $urandom;
      end else begin
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
      end
      #1;
      check("stall", mem_stall, 32'(k < stall_n));
      check("req", dmem_req, 32'(k >= 1 && k <= busy_n));
      check("redirect", pc_redirect, 32'(redir));
      check("target", pc_target, jmp ? ja : ba);
      check("flush", flush, 32'(redir && !(k < stall_n)));
      if (dmem_req) begin
        req_seen++;
        if (dmem_we) we_seen++;
        check("addr", dmem_addr, addr);
        check("wdata", dmem_wdata, wd);
      end
      if (k >= 1) begin
        check("bubble_rw", wb_RegWrite, 0);
        check("bubble_mtr", wb_MemtoReg, 0);
      end
      if (k >= stall_n) begin
        finished = 1;
        break;
      end
    end
    if (!finished) check("txn_bound", 0, 1);
    @(posedge clk);
    #1;
    if (aligned && !tout) exp_rdata = rdv;
    if (mis || tout) exp_err = 1'b1;
    check("req_cycles", 32'(req_seen), 32'(busy_n));
    check("we_cycles", 32'(we_seen), mw ? 32'(busy_n) : 0);
    check("wb_rw", wb_RegWrite, 32'(rw && !mis && !tout));
    check("wb_mtr", wb_MemtoReg, 32'(mtr));
    check("wb_alu", wb_alu_result, addr);
    check("wb_rd", wb_rd, 32'(rdn));
    check("wb_rdata", wb_read_data, exp_rdata);
    check("mem_error", mem_error, 32'(exp_err));
    dmem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int d, op;
    rst = 1'b1;
    clear_inputs();
    exp_err = 1'b0;
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rw", wb_RegWrite, 0);
    check("rst_rdata", wb_read_data, 0);
    check("rst_err", mem_error, 0);
    check("rst_req", dmem_req, 0);
    rst = 1'b0;

    // load, ready 3 cycles after request
    run_txn(1, 0, 1, 1, 0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd3, 3);
    // store, ready with request
    run_txn(0, 1, 0, 0, 0, 0, 0, 32'h204, 32'h12345678, 32'h55AA55AA, 32'h0, 32'h0, 5'd0, 0);
    // branch taken / not taken, jump priority
    run_txn(0, 0, 1, 0, 1, 1, 0, 32'h7, 32'h0, 32'h0, 32'h0, 32'h40, 5'd4, 0);
    run_txn(0, 0, 1, 0, 1, 0, 0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h40, 5'd5, 0);
    run_txn(0, 0, 0, 0, 1, 1, 1, 32'h9, 32'h0, 32'h0, 32'h80, 32'h40, 5'd6, 0);
    // misaligned load, then last-chance ready and full timeout
    run_txn(1, 0, 1, 1, 0, 0, 0, 32'h102, 32'h0, 32'h11111111, 32'h0, 32'h0, 5'd7, 0);
    run_txn(1, 0, 1, 1, 0, 0, 0, 32'h110, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd8, 14);
    run_txn(1, 0, 1, 1, 1, 1, 0, 32'h120, 32'h0, 32'h22222222, 32'h0, 32'h60, 5'd9, 99);

    // reset in second BUSY cycle, with ready also high on that edge
    @(negedge clk);
    MemRead = 1'b1; RegWrite = 1'b1; MemtoReg = 1'b1; ALU_result = 32'h300; rd = 5'd12;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("busy2_req", dmem_req, 1);
    rst = 1'b1;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("rstb_req", dmem_req, 0);
    check("rstb_rw", wb_RegWrite, 0);
    check("rstb_rdata", wb_read_data, 0);
    check("rstb_alu", wb_alu_result, 0);
    check("rstb_err", mem_error, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    exp_err = 1'b0;
    exp_rdata = '0;

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 15);
      run_txn(op == 1, op == 2, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), a, $urandom, $urandom, $urandom, $urandom, 5'($urandom), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, maximum cycles BUSY waits for dmem_ready before abort.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have inputs from the EX/MEM pipeline register, all 1 bit unless noted: RegWrite, MemtoReg, Branch, MemRead, MemWrite, Jump, ALU_zero; jump_addr, branch_addr, ALU_result, wdata  in  32; rd  in  5.
REQ-004 SHALL have data-memory ports: dmem_req  out  1  request; dmem_we  out  1  write enable; dmem_addr, dmem_wdata  out  32; dmem_ready  in  1  completion; dmem_rdata  in  32  load data.
REQ-005 SHALL have control outputs: mem_stall  out  1  freeze upstream; pc_redirect  out  1; pc_target  out  32; flush  out  1  clear IF/ID, ID/EX, EX/MEM controls; mem_error  out  1  sticky fault.
REQ-006 SHALL have MEM/WB outputs: wb_RegWrite, wb_MemtoReg  out  1; wb_read_data, wb_alu_result  out  32; wb_rd  out  5.

Function
REQ-007 SHALL define access = MemRead|MemWrite and misalign = access & (ALU_result[1:0]!=0).
REQ-008 SHALL implement FSM IDLE, BUSY; IDLE->BUSY on rising edge when access & !misalign.
REQ-009 SHALL drive dmem_req=(state==BUSY), dmem_we=MemWrite, dmem_addr=ALU_result, dmem_wdata=wdata, combinationally.
REQ-010 SHALL hold BUSY while !dmem_ready; BUSY->IDLE on edge where dmem_ready=1.
REQ-011 SHALL assert mem_stall=(IDLE & access & !misalign) | (BUSY & !dmem_ready), combinationally; minimum access latency 2 cycles.
REQ-012 SHALL count BUSY cycles with a 4-bit counter cleared on BUSY entry; when count reaches TIMEOUT with dmem_ready=0, SHALL go IDLE, set mem_error, deassert stall, and retire the instruction with wb_RegWrite=0.
REQ-013 SHALL compute pc_redirect=Jump | (Branch & ALU_zero); pc_target=jump_addr when Jump, else branch_addr (Jump priority).
REQ-014 SHALL assert flush=pc_redirect & !mem_stall.
REQ-015 SHALL update MEM/WB outputs on rising edge when !mem_stall: wb_RegWrite<=RegWrite & !misalign, wb_MemtoReg<=MemtoReg, wb_alu_result<=ALU_result, wb_rd<=rd, wb_read_data<=dmem_rdata when BUSY & dmem_ready.
REQ-016 SHALL insert a bubble (wb_RegWrite<=0, wb_MemtoReg<=0) on every edge with mem_stall=1.
REQ-017 SHALL, on misaligned access, issue no request, set mem_error, and retire with RegWrite suppressed.
REQ-018 SHALL ignore dmem_ready while IDLE.

Reset
REQ-019 SHALL on rst: state=IDLE, counter=0, mem_error=0, all wb_* outputs 0.
REQ-020 SHALL abort an in-flight BUSY access on rst; dmem_req low from the following cycle.
REQ-021 SHALL give rst priority over dmem_ready and timeout on the same edge.

Structure
REQ-022 SHALL place FSM state enum, TIMEOUT default, and counter width in shared package cpu_pkg.
REQ-023 SHALL implement MEM/WB register as sub-module mem_wb, instantiated once, with enable=!mem_stall and bubble input=mem_stall.

Verification
REQ-024 Load ALU_result=0x100, dmem_ready 3 cycles after req, rdata=0xDEADBEEF -> stall 4 cycles, wb_read_data=0xDEADBEEF, wb_RegWrite=1.
REQ-025 Store ALU_result=0x204, wdata=0x12345678, ready same cycle as req -> dmem_we=1 one cycle, wb_RegWrite=0, stall 1 cycle.
REQ-026 Branch=1, ALU_zero=1, branch_addr=0x40 -> pc_redirect=1, pc_target=0x40, flush=1; ALU_zero=0 -> redirect=0.
REQ-027 Jump=1 and Branch=1, ALU_zero=1, jump_addr=0x80 -> pc_target=0x80.
REQ-028 Load at 0x102 -> no dmem_req, mem_error=1, wb_RegWrite=0; dmem_ready never asserted -> abort after 15 BUSY cycles, mem_error=1.
REQ-029 rst asserted in 2nd BUSY cycle -> state IDLE, dmem_req=0, wb_* = 0 next cycle.
